alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered successor to the 4-bit CLA ALU slice. It performs WIDTH-bit logic, add/subtract, set-less-than and multi-cycle shifts. Operations enter through a valid/ready input handshake, and results leave through a registered valid/ready output stage with backpressure. The block sits between operand fetch and writeback in the datapath, replacing chains of 4-bit slices.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4
- SHW, $clog2(WIDTH), derived; shift-amount width, not overridden

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept this cycle
- a, b  in  WIDTH  operands; for shifts, amount = b[SHW-1:0]
- op  in  4  operation code
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- cout  out  1  adder carry out (ADD/SUB/SLT), else 0
- overflow  out  1  signed overflow (ADD/SUB/SLT), else 0
- set  out  1  signed a<b: sum msb XOR overflow (ADD/SUB/SLT), else 0
- zero  out  1  result == 0

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 1100 NOR
  - 0010 ADD
  - 0110 SUB (a + ~b + 1)
  - 0111 SLT (result = {0…, set})
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
- Any other op: result 0, all flags 0 except zero = 1; treated as single-cycle.
- Arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH-1. overflow = carry into msb XOR carry out of msb.
- Transfer occurs when in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- FSM states:
  - IDLE → SHIFT on accepting a shift with amount n > 0. Load acc = a and cnt = n.
  - SHIFT: each cycle, acc shifts by one bit (SLL: zero-fill; SRL: zero-fill; SRA: msb-fill) and cnt decrements. On the cycle where cnt == 1, the shifted value goes to the output register, out_valid is set and the FSM returns to IDLE.
- Single-cycle ops and shifts with n = 0 load the output register directly from IDLE. A shift with n = 0 returns a unchanged.
- The output register holds result and flags stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result loads on the same edge.
- Back-to-back single-cycle ops sustain one result per cycle while out_ready = 1.
- zero is computed from the value being loaded into result and is registered alongside it.
- Reset (any time, including mid-SHIFT) aborts the operation:
  - state = IDLE, out_valid = 0, result = 0
  - cout = overflow = set = zero = 0
  - acc and cnt = 0
  - no partial result is emitted.

## Timing
- Latency, with accept on edge E:
  - single-cycle ops and shift n = 0: out_valid high after edge E.
  - shift n ≥ 1: out_valid high after edge E+n.
- in_ready is low for all cycles in SHIFT and while a held result is unconsumed.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid, a, b or op to any output.
- Carry chain: 4-bit CLA groups. Group G/P feed a second-level lookahead across WIDTH/4 groups. The chain must close in one cycle at target frequency.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_SRA)
  - the FSM state encoding (IDLE, SHIFT)
  - the flag-bundle typedef {cout, overflow, set, zero}.
- Sub-module cla_adder (parameter WIDTH): purely combinational. Inputs a, b, cin. Outputs sum, cout, c_msb (carry into msb), G, P. Built from 4-bit lookahead groups.
- Top level holds the handshake, FSM, shift datapath and output register.

## Test plan
WIDTH = 16 throughout.
- ADD 0x7FFF + 0x0001 → result 0x8000, overflow = 1, cout = 0, zero = 0, set = 0. out_valid one cycle after accept.
- SUB 0x0005 − 0x0005 → result 0x0000, zero = 1, cout = 1, overflow = 0.
- SLT a = 0xFFFF, b = 0x0001 → result 0x0001, set = 1. SLT a = 0x0001, b = 0xFFFF → result 0x0000, set = 0, zero = 1.
- SRA a = 0x8000, b = 3 → in_ready low 3 cycles, then result 0xF000. SRL of the same operands → 0x1000. SLL 0x0001 by 0 → 0x0001 with single-cycle latency.
- ADD result held with out_ready = 0 for 4 cycles: result and flags stable, in_ready = 0 throughout. With out_ready = 1 and a queued AND 0x0F0F & 0x00FF, the next result is 0x000F on the following edge.
- reset asserted mid-SLL (a = 0x0001, b = 15) on its 5th shift cycle → out_valid = 0 and all outputs 0 immediately. After release, in_ready = 1 and no stale result ever appears.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, FSM state encoding, shift kinds and the
//                flag bundle for the pipelined ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    // Control FSM: single-cycle work happens in IDLE, shifts iterate in SHIFT
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Direction / fill of the iterative shifter
    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

    // Status flags registered alongside the result
    typedef struct packed {
        logic cout;
        logic overflow;
        logic set;
        logic zero;
    } alu_flags_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_adder
//  Description : Combinational two-level carry-lookahead adder. 4-bit groups
//                produce group generate/propagate; a second lookahead level
//                forms every group carry directly from cin.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb,
    output logic             G,
    output logic             P
);

    localparam int NG = WIDTH / 4;

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [NG-1:0]    gen_pre;
    logic [NG-1:0]    prop_pre;
    logic [WIDTH-1:0] bit_c;

    // First level: per-group bit carries, group G/P and sum bits
    for (genvar k = 0; k < NG; k++) begin : g_group
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;

        assign gg = a[4*k +: 4] & b[4*k +: 4];
        assign pp = a[4*k +: 4] ^ b[4*k +: 4];
        assign ci = grp_c[k];

        assign bit_c[4*k]   = ci;
        assign bit_c[4*k+1] = gg[0] | (pp[0] & ci);
        assign bit_c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        assign bit_c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                            | (pp[2] & pp[1] & pp[0] & ci);

        assign grp_g[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                        | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p[k] = &pp;

        assign sum[4*k +: 4] = pp ^ bit_c[4*k +: 4];
    end

    // Second level: flat lookahead of each group carry from the group G/P terms
    always_comb begin
        logic term;
        logic acc_g;
        logic acc_p;
        term     = 1'b0;
        acc_g    = 1'b0;
        acc_p    = 1'b0;
        gen_pre  = '0;
        prop_pre = '0;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            acc_g = 1'b0;
            for (int j = 0; j <= k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & grp_p[m];
                end
                acc_g = acc_g | term;
            end
            acc_p = 1'b1;
            for (int m = 0; m <= k; m++) begin
                acc_p = acc_p & grp_p[m];
            end
            gen_pre[k]  = acc_g;
            prop_pre[k] = acc_p;
            grp_c[k+1]  = acc_g | (acc_p & cin);
        end
    end

    assign cout  = grp_c[NG];
    assign c_msb = bit_c[WIDTH-1];
    assign G     = gen_pre[NG-1];
    assign P     = prop_pre[NG-1];

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Registered WIDTH-bit ALU with valid/ready input handshake,
//                iterative one-bit-per-cycle shifter and a backpressured
//                output register carrying result and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             set,
    output logic             zero
);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [SHW-1:0]   cnt_q,       cnt_d;
    shift_kind_t      kind_q,      kind_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    alu_flags_t       flags_q,     flags_d;

    logic             w_sub_like;
    logic [WIDTH-1:0] w_b_add;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_cout;
    logic             w_c_msb;
    logic             w_blk_g;
    logic             w_blk_p;
    logic             w_cout;
    logic             w_ovf;
    logic             w_set;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;
    logic [SHW-1:0]   w_shamt;
    shift_kind_t      w_kind;
    logic [WIDTH-1:0] w_acc_step;
    logic             w_accept;

    // SUB and SLT both compute a + ~b + 1
    assign w_sub_like = (op == OP_SUB) || (op == OP_SLT);
    assign w_b_add    = w_sub_like ? ~b : b;

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a     (a),
        .b     (w_b_add),
        .cin   (w_sub_like),
        .sum   (w_sum),
        .cout  (w_add_cout),
        .c_msb (w_c_msb),
        .G     (w_blk_g),
        .P     (w_blk_p)
    );

    // Carry-out flag from the block-level generate/propagate pair; overflow
    // compares the ripple-visible carry into the msb against the adder's cout
    assign w_cout  = w_blk_g | (w_blk_p & w_sub_like);
    assign w_ovf   = w_c_msb ^ w_add_cout;
    assign w_set   = w_sum[WIDTH-1] ^ w_ovf;
    assign w_shamt = b[SHW-1:0];

    // Single-cycle result and flags for the op presented at the input
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (op)
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_NOR: w_res = ~(a | b);
            OP_ADD, OP_SUB: begin
                w_res            = w_sum;
                w_flags.cout     = w_cout;
                w_flags.overflow = w_ovf;
                w_flags.set      = w_set;
            end
            OP_SLT: begin
                w_res            = {{(WIDTH-1){1'b0}}, w_set};
                w_flags.cout     = w_cout;
                w_flags.overflow = w_ovf;
                w_flags.set      = w_set;
            end
            OP_SLL, OP_SRL, OP_SRA: w_res = a;  // only reached for amount 0
            default: w_res = '0;
        endcase
        w_flags.zero = (w_res == '0);
    end

    // Shift direction captured when a multi-cycle shift is accepted
    always_comb begin
        w_kind = SH_LL;
        if (op == OP_SRL) begin
            w_kind = SH_RL;
        end else if (op == OP_SRA) begin
            w_kind = SH_RA;
        end
    end

    // One-bit step of the iterative shifter
    always_comb begin
        case (kind_q)
            SH_LL:   w_acc_step = {acc_q[WIDTH-2:0], 1'b0};
            SH_RL:   w_acc_step = {1'b0, acc_q[WIDTH-1:1]};
            SH_RA:   w_acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: w_acc_step = acc_q;
        endcase
    end

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;

    // Next-state for FSM, shifter and output register
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (is_shift_op(op) && (w_shamt != '0)) begin
                        state_d = SHIFT;
                        acc_d   = a;
                        cnt_d   = w_shamt;
                        kind_d  = w_kind;
                    end else begin
                        result_d    = w_res;
                        flags_d     = w_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d      = IDLE;
                    result_d     = w_acc_step;
                    flags_d      = '0;
                    flags_d.zero = (w_acc_step == '0);
                    out_valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any shift in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            kind_q      <= SH_LL;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = flags_q.cout;
    assign overflow  = flags_q.overflow;
    assign set       = flags_q.set;
    assign zero      = flags_q.zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (WIDTH = 16): directed
//                cases plus randomized traffic against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             set;
    logic             zero;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] exp_q[$];

    alu_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .set       (set),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {result, cout, overflow, set, zero} from plain integer arithmetic
    function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        int sx, sy, t;
        logic [15:0] r;
        logic c, v, s;
        sx = $signed(x);
        sy = $signed(y);
        t = 0; r = '0; c = 1'b0; v = 1'b0; s = 1'b0;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin
                t = sx + sy;
                r = x + y;
                c = (int'(x) + int'(y)) > 65535;
                v = (t > 32767) || (t < -32768);
                s = (t < 0);
            end
            4'b0110, 4'b0111: begin
                t = sx - sy;
                c = (x >= y);
                v = (t > 32767) || (t < -32768);
                s = (t < 0);
                r = (o == 4'b0110) ? 16'(x - y) : {15'd0, s};
            end
            4'b1000: r = x << y[3:0];
            4'b1001: r = x >> y[3:0];
            4'b1010: r = 16'($signed(x) >>> y[3:0]);
            default: r = '0;
        endcase
        return {r, c, v, s, (r == 16'd0)};
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [15:0] y);
        if ((o == 4'b1000 || o == 4'b1001 || o == 4'b1010) && y[3:0] != 4'd0)
            return int'(y[3:0]);
        return 0;
    endfunction

    function automatic logic [19:0] observed();
        return {result, cout, overflow, set, zero};
    endfunction

    // Issue one op (caller holds out_ready) and check latency, ready gap and value
    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        int guard;
        int lat;
        int low;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(model_lat(o, y)));
        check({tag, "_busy"}, 32'(low), 32'(model_lat(o, y)));
        check({tag, "_val"}, 32'(observed()), 32'(model(o, x, y)));
    endtask

    logic [3:0] op_tab [12];
    logic [19:0] held;
    int seen;

    initial begin
        op_tab = '{4'b0000, 4'b0001, 4'b1100, 4'b0010, 4'b0110, 4'b0111,
                   4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1111, 4'b0100};
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_outs", 32'(observed()), 32'd0);
        check("rst_inrdy", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op("add_ovf", 4'b0010, 16'h7FFF, 16'h0001);
        run_op("sub_zero", 4'b0110, 16'h0005, 16'h0005);
        run_op("slt_neg", 4'b0111, 16'hFFFF, 16'h0001);
        run_op("slt_pos", 4'b0111, 16'h0001, 16'hFFFF);
        run_op("sra3", 4'b1010, 16'h8000, 16'h0003);
        run_op("srl3", 4'b1001, 16'h8000, 16'h0003);
        run_op("sll0", 4'b1000, 16'h0001, 16'h0000);
        run_op("bad_op", 4'b1111, 16'h1234, 16'h5678);

        // Backpressure: hold an ADD result while an AND waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op("hold_add", 4'b0010, 16'h1234, 16'h4321);
        held = observed();
        in_valid = 1'b1; op = 4'b0000; a = 16'h0F0F; b = 16'h00FF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_val", 32'(observed()), 32'(held));
            check("hold_ovalid", 32'(out_valid), 32'd1);
            check("hold_inrdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("rel_inrdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rel_ovalid", 32'(out_valid), 32'd1);
        check("rel_and", 32'(observed()), 32'(model(4'b0000, 16'h0F0F, 16'h00FF)));
        @(posedge clk); #1;

        // Reset during a long shift
        in_valid = 1'b1; op = 4'b1000; a = 16'h0001; b = 16'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_outs", 32'(observed()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_inrdy", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_stale", 32'(seen), 32'd0);

        // Randomized traffic through the scoreboard
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = op_tab[$urandom_range(0, 11)];
            a         = 16'($urandom);
            b         = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rnd_spurious", 32'd1, 32'd0);
                else check("rnd_res", 32'(observed()), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
            @(posedge clk); #1;
        end

        // Drain whatever is still in flight
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 40 && exp_q.size() != 0; g++) begin
            #1;
            if (out_valid) check("drain_res", 32'(observed()), 32'(exp_q.pop_front()));
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
